// File: rtl/ram_refresh_sched_pkg.sv
// Shared types and default constants for the DRAM refresh scheduler.
package ram_refresh_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    GAP  = 2'd2
  } refState_t;

  localparam int REF_PERIOD_DEF = 384;
  localparam int DEBT_W_DEF     = 3;
  localparam int DEBT_MAX_DEF   = 7;
  localparam int URG_THRESH_DEF = 2;

endpackage

// File: rtl/ram_refresh_sched_timer.sv
// Free-running refresh slot timer: counts down, reloads, ticks at zero.
module ram_refresh_sched_timer #(
  parameter int PERIOD = 384
) (
  input  logic CLK,
  input  logic RST,
  input  logic En,
  output logic Tick
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= RELOAD;
    end else if (En) begin
      count <= (count == '0) ? RELOAD : count - ONE;
    end
  end

  assign Tick = En && (count == '0);

endmodule

// File: rtl/ram_refresh_sched.sv
// Refresh scheduler: paces slots, tracks debt, drives req/urgent/stall.
module ram_refresh_sched
  import ram_refresh_sched_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEF,
  parameter int DEBT_W     = DEBT_W_DEF,
  parameter int DEBT_MAX   = DEBT_MAX_DEF,
  parameter int URG_THRESH = URG_THRESH_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              RefAck,
  output logic              RefReq,
  output logic              RefUrg,
  output logic              StallReq,
  output logic [DEBT_W-1:0] Debt,
  output logic              Overflow,
  output logic              AckErr
);

  localparam logic [DEBT_W-1:0] DMAX = DEBT_W'(DEBT_MAX);
  localparam logic [DEBT_W-1:0] UTH  = DEBT_W'(URG_THRESH);
  localparam logic [DEBT_W-1:0] ONE  = DEBT_W'(1);

  logic              tick;
  logic              accAck;
  logic              ovfNxt;
  logic              errNxt;
  logic [DEBT_W-1:0] debtNxt;
  refState_t         state;
  refState_t         stateNxt;

  ram_refresh_sched_timer #(
    .PERIOD(REF_PERIOD)
  ) refPeriodTimer (
    .CLK (CLK),
    .RST (RST),
    .En  (EN),
    .Tick(tick)
  );

  always_comb begin
    stateNxt = state;
    debtNxt  = Debt;
    ovfNxt   = Overflow;
    accAck   = EN && RefAck && (state == PEND) && (Debt != '0);
    errNxt   = AckErr || (RefAck && !accAck);
    if (EN) begin
      // tick and ack in the same clock cancel out
      if (tick && !accAck) begin
        if (Debt == DMAX) ovfNxt = 1'b1;
        else              debtNxt = Debt + ONE;
      end else if (accAck && !tick) begin
        debtNxt = Debt - ONE;
      end
      unique case (state)
        IDLE:    if (debtNxt != '0) stateNxt = PEND;
        PEND:    if (accAck) stateNxt = GAP;
        GAP:     stateNxt = (debtNxt != '0) ? PEND : IDLE;
        default: stateNxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      Debt     <= '0;
      Overflow <= 1'b0;
      AckErr   <= 1'b0;
      RefReq   <= 1'b0;
      RefUrg   <= 1'b0;
      StallReq <= 1'b0;
    end else begin
      state    <= stateNxt;
      Debt     <= debtNxt;
      Overflow <= ovfNxt;
      AckErr   <= errNxt;
      RefReq   <= EN && (stateNxt == PEND) && (debtNxt != '0);
      RefUrg   <= EN && (stateNxt == PEND) && (debtNxt >= UTH);
      StallReq <= EN && (debtNxt == DMAX);
    end
  end

endmodule

// File: tb/tb_ram_refresh_sched.sv
// Self-checking bench for ram_refresh_sched with a slot/debt reference model.
module tb_ram_refresh_sched;

  localparam int P    = 8;
  localparam int DMAX = 7;
  localparam int UTH  = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic       RefAck = 1'b0;
  logic       RefReq, RefUrg, StallReq, Overflow, AckErr;
  logic [2:0] Debt;

  int nChecks = 0;
  int nFail = 0;

  // reference model: remaining clocks to next slot, owed refreshes,
  // and whether the previous clock consumed a refresh (request gap)
  int mTimer, mDebt;
  bit mGap, mOv, mErr, mEn;
  bit eReq, eUrg, eStall;

  ram_refresh_sched #(
    .REF_PERIOD(P),
    .DEBT_W    (3),
    .DEBT_MAX  (DMAX),
    .URG_THRESH(UTH)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .RefAck  (RefAck),
    .RefReq  (RefReq),
    .RefUrg  (RefUrg),
    .StallReq(StallReq),
    .Debt    (Debt),
    .Overflow(Overflow),
    .AckErr  (AckErr)
  );

  always #5 CLK = ~CLK;

  task automatic mdl_edge();
    bit tk, acc;
    if (RST) begin
      mTimer = P - 1; mDebt = 0; mGap = 0;
      mOv = 0; mErr = 0; mEn = 0;
    end else begin
      acc = EN && RefAck && !mGap && mDebt > 0;
      if (RefAck && !acc) mErr = 1;
      mEn = EN;
      if (EN) begin
        tk = (mTimer == 0);
        mTimer = tk ? P - 1 : mTimer - 1;
        if (tk && !acc) begin
          if (mDebt == DMAX) mOv = 1;
          else mDebt++;
        end else if (acc && !tk) begin
          mDebt--;
        end
        mGap = acc;
      end
    end
    eReq   = mEn && !mGap && mDebt > 0;
    eUrg   = mEn && !mGap && mDebt >= UTH;
    eStall = mEn && mDebt == DMAX;
  endtask

  task automatic clk1();
    @(posedge CLK);
    mdl_edge();
    #1;
  endtask

  task automatic do_reset();
    RST = 1; RefAck = 0;
    clk1(); clk1();
    RST = 0;
  endtask

  task automatic test_reset();
    EN = 1;
    do_reset();
    nChecks++;
    if ({RefReq, RefUrg, StallReq, Overflow, AckErr} !== 5'b0) begin
      nFail++;
      $display("FAIL reset_flags got=%b want=00000",
               {RefReq, RefUrg, StallReq, Overflow, AckErr});
    end
    nChecks++;
    if (Debt !== 3'd0) begin
      nFail++; $display("FAIL reset_debt got=%0d want=0", Debt);
    end
  endtask

  task automatic test_fill();
    int fReq = -1, fUrg = -1, fStall = -1, fOv = -1;
    EN = 1;
    do_reset();
    for (int i = 1; i <= 9 * P; i++) begin
      clk1();
      if (RefReq && fReq < 0) fReq = i;
      if (RefUrg && fUrg < 0) fUrg = i;
      if (StallReq && fStall < 0) fStall = i;
      if (Overflow && fOv < 0) fOv = i;
      nChecks++;
      if (Debt !== 3'(mDebt) || RefReq !== eReq) begin
        nFail++;
        $display("FAIL fill_cyc%0d debt=%0d req=%b want debt=%0d req=%b",
                 i, Debt, RefReq, mDebt, eReq);
      end
    end
    nChecks++;
    if (fReq != P) begin
      nFail++; $display("FAIL first_req cycle=%0d want=%0d", fReq, P);
    end
    nChecks++;
    if (fUrg != 2 * P) begin
      nFail++; $display("FAIL first_urg cycle=%0d want=%0d", fUrg, 2 * P);
    end
    nChecks++;
    if (fStall != 7 * P) begin
      nFail++; $display("FAIL first_stall cycle=%0d want=%0d", fStall, 7 * P);
    end
    nChecks++;
    if (fOv != 8 * P || Debt !== 3'd7) begin
      nFail++;
      $display("FAIL overflow cycle=%0d debt=%0d want cycle=%0d debt=7",
               fOv, Debt, 8 * P);
    end
  endtask

  task automatic test_ack_single();
    EN = 1;
    do_reset();
    repeat (P) clk1();
    RefAck = 1; clk1(); RefAck = 0;
    nChecks++;
    if (RefReq !== 1'b0 || Debt !== 3'd0 || AckErr !== 1'b0) begin
      nFail++;
      $display("FAIL ack1 req=%b debt=%0d err=%b want 0 0 0",
               RefReq, Debt, AckErr);
    end
    repeat (4) begin
      clk1();
      nChecks++;
      if (RefReq !== 1'b0) begin
        nFail++; $display("FAIL ack1_noreassert req=%b want=0", RefReq);
      end
    end
  endtask

  task automatic test_ack_debt3();
    EN = 1;
    do_reset();
    repeat (3 * P) clk1();
    RefAck = 1; clk1(); RefAck = 0;
    nChecks++;
    if (Debt !== 3'd2 || RefReq !== 1'b0 || RefUrg !== 1'b0) begin
      nFail++;
      $display("FAIL ack3_gap debt=%0d req=%b urg=%b want 2 0 0",
               Debt, RefReq, RefUrg);
    end
    clk1();
    nChecks++;
    if (Debt !== 3'd2 || RefReq !== 1'b1 || RefUrg !== 1'b1) begin
      nFail++;
      $display("FAIL ack3_back debt=%0d req=%b urg=%b want 2 1 1",
               Debt, RefReq, RefUrg);
    end
  endtask

  task automatic test_ack_tick();
    EN = 1;
    do_reset();
    repeat (3 * P - 1) clk1();
    RefAck = 1; clk1(); RefAck = 0;
    nChecks++;
    if (Debt !== 3'd2 || RefUrg !== 1'b0 || RefReq !== 1'b0) begin
      nFail++;
      $display("FAIL acktick_gap debt=%0d req=%b urg=%b want 2 0 0",
               Debt, RefReq, RefUrg);
    end
    clk1();
    nChecks++;
    if (RefUrg !== 1'b1 || Debt !== 3'd2) begin
      nFail++;
      $display("FAIL acktick_back urg=%b debt=%0d want 1 2", RefUrg, Debt);
    end
  endtask

  task automatic test_ack_err();
    EN = 1;
    do_reset();
    RefAck = 1; clk1(); RefAck = 0;
    nChecks++;
    if (AckErr !== 1'b1 || Debt !== 3'd0) begin
      nFail++;
      $display("FAIL ackerr_zero err=%b debt=%0d want 1 0", AckErr, Debt);
    end
    do_reset();
    repeat (2 * P) clk1();
    RefAck = 1; clk1();
    clk1(); RefAck = 0;
    nChecks++;
    if (AckErr !== 1'b1 || Debt !== 3'd1) begin
      nFail++;
      $display("FAIL ackerr_gap err=%b debt=%0d want 1 1", AckErr, Debt);
    end
    repeat (5) clk1();
    nChecks++;
    if (AckErr !== 1'b1) begin
      nFail++; $display("FAIL ackerr_sticky err=%b want=1", AckErr);
    end
    do_reset();
    nChecks++;
    if (AckErr !== 1'b0) begin
      nFail++; $display("FAIL ackerr_clear err=%b want=0", AckErr);
    end
  endtask

  task automatic test_enable();
    int incAt = -1;
    EN = 1;
    do_reset();
    repeat (P + 2) clk1();
    EN = 0;
    for (int i = 0; i < 20; i++) begin
      clk1();
      nChecks++;
      if (RefReq !== 1'b0 || RefUrg !== 1'b0 || Debt !== 3'd1) begin
        nFail++;
        $display("FAIL en_low%0d req=%b urg=%b debt=%0d want 0 0 1",
                 i, RefReq, RefUrg, Debt);
      end
    end
    EN = 1;
    clk1();
    nChecks++;
    if (RefReq !== 1'b1) begin
      nFail++; $display("FAIL en_resume req=%b want=1", RefReq);
    end
    for (int j = 2; j <= P; j++) begin
      clk1();
      if (Debt == 3'd2 && incAt < 0) incAt = j;
    end
    // frozen with 5 clocks left, so the slot lands on the 6th edge
    nChecks++;
    if (incAt != 6) begin
      nFail++; $display("FAIL en_next_tick edge=%0d want=6", incAt);
    end
  endtask

  task automatic test_random();
    EN = 1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(0, 499) == 0);
      EN = ($urandom_range(0, 9) != 0);
      RefAck = EN && ($urandom_range(0, 3) == 0);
      clk1();
      nChecks++;
      if (RefReq !== eReq || RefUrg !== eUrg || StallReq !== eStall ||
          Debt !== 3'(mDebt) || Overflow !== mOv || AckErr !== mErr) begin
        nFail++;
        $display("FAIL rand%0d got r%b u%b s%b d%0d o%b e%b want r%b u%b s%b d%0d o%b e%b",
                 i, RefReq, RefUrg, StallReq, Debt, Overflow, AckErr,
                 eReq, eUrg, eStall, mDebt, mOv, mErr);
      end
    end
    RST = 0; RefAck = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ack_single();
    test_ack_debt3();
    test_ack_tick();
    test_ack_err();
    test_enable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/ram_refresh_sched.md
# ram_refresh_sched

DRAM refresh scheduler that feeds the RAM controller's refresh-request inputs. It paces refresh slots with a free-running period timer and tracks postponed refreshes in a saturating debt counter. It raises a normal request while any refresh is owed and an urgent request once debt reaches a threshold. After each refresh acknowledge it inserts a one-cycle request gap, so the controller's refresh-done latch clears and re-arms.

## Interface
Parameters:
- REF_PERIOD, 384, clocks between refresh slots (≥4)
- DEBT_W, 3, width of debt counter
- DEBT_MAX, 7, saturation value of debt (≤2^DEBT_W−1)
- URG_THRESH, 2, debt level at which RefUrg asserts (1..DEBT_MAX)

Ports:
- CLK  in  1  system clock, all logic on posedge
- RST  in  1  synchronous, active-high reset
- EN  in  1  scheduler enable; low freezes timer and debt, forces request outputs low
- RefAck  in  1  one-cycle pulse from RAM controller on the clock it enters refresh RAS
- RefReq  out  1  registered; a refresh is owed (controller's RefReqIn)
- RefUrg  out  1  registered; refresh overdue (controller's RefUrgIn)
- StallReq  out  1  registered; debt == DEBT_MAX, CPU cycle-stretch request
- Debt  out  DEBT_W  current debt count
- Overflow  out  1  sticky; a slot tick was lost at saturation
- AckErr  out  1  sticky; RefAck received with no debt or during GAP

## Operation
- Timer: counts down from REF_PERIOD−1; at 0 it produces a tick and reloads REF_PERIOD−1. It holds while EN is low.
- Debt update per clock (EN high): tick and accepted ack together → unchanged; tick only → +1; accepted ack only → −1.
- Saturation: a tick at DEBT_MAX leaves Debt at DEBT_MAX and sets Overflow. Debt never wraps.
- Ack acceptance: accepted only in state PEND with Debt>0. Otherwise it is ignored, Debt is unchanged, and AckErr is set.
- FSM states:
  - IDLE: Debt==0, outputs low.
  - PEND: Debt>0, requests driven.
  - GAP: one cycle with requests forced low.
- Transitions:
  - IDLE→PEND when next Debt>0.
  - PEND→GAP on accepted ack.
  - GAP→PEND if Debt>0, else GAP→IDLE.
  - Any state→IDLE-equivalent output hold while EN low. The state itself is retained; outputs are forced low.
- Outputs, all registered from next-state:
  - RefReq = (state PEND) && Debt≥1
  - RefUrg = (state PEND) && Debt≥URG_THRESH
  - StallReq = Debt==DEBT_MAX, independent of GAP
- Sticky flags clear only on RST.

## Timing
- Reset values:
  - Timer = REF_PERIOD−1, Debt = 0, state IDLE
  - RefReq = RefUrg = StallReq = Overflow = AckErr = 0
- Tick latency: the timer reaches 0 at edge k. Debt increments and RefReq rises at edge k+1.
- Ack response: RefAck is sampled high at edge k. Debt decrements, state becomes GAP, and RefReq/RefUrg are low after edge k. They reassert after edge k+1 if debt remains.
- GAP is exactly one cycle. A tick during GAP still increments Debt. An ack during GAP is an AckErr.
- First slot after reset: RefReq rises REF_PERIOD clocks after RST deasserts.
- RST mid-refresh: all state returns to reset values on that edge. The controller's in-flight refresh is not tracked.
- EN falling: outputs go low the next edge. EN rising: the timer resumes from its held value.

## Structure
- Shared package holds the FSM state encoding (IDLE/PEND/GAP), default REF_PERIOD, and DEBT_W/DEBT_MAX/URG_THRESH constants.
- One natural sub-module: ref_period_timer (down-counter, reload, enable, tick output).

## Test plan
- Reset, EN=1, REF_PERIOD=8, no acks → RefReq rises 8 clocks after reset, Debt increments every 8 clocks, RefUrg rises when Debt=2, StallReq rises at Debt=7. The 8th tick sets Overflow with Debt held at 7.
- Debt=1, pulse RefAck in PEND → RefReq low the next cycle, Debt=0, state IDLE, no reassert.
- Debt=3, single RefAck → Debt=2, exactly one low cycle on RefReq/RefUrg, then both high again.
- RefAck coincident with tick at Debt=2 → Debt stays 2, GAP still inserted, RefUrg reasserts after one cycle.
- RefAck at Debt=0, and RefAck during GAP → Debt unchanged, AckErr=1 and stays set until RST.
- EN low for 20 clocks with Debt=1 → outputs low and timer frozen. On EN high, RefReq returns the next edge and the next tick arrives after the remaining count.
